// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Single-outstanding-request instruction fetch stage. Issues a read to the
//   instruction memory, presents the returned word to the decode stage and
//   follows redirects from the next-PC logic. A redirect that arrives while a
//   read is outstanding marks the in-flight word stale so it is dropped on ack.
//
//   Optional feature: define FETCH_MISALIGN_TRAP_EN to trap redirects whose
//   target is not word aligned (sticky fetch_misalign, fetch halts until rst).
//   Without it the low two target bits are cleared and fetch_misalign is 0.
//
// Parameters
//   RESET_PC        first fetch address after reset
// Ports
//   clk             clock, all state on rising edge
//   rst             synchronous active-high reset
//   redirect_valid  taken branch/jump this cycle
//   redirect_addr   branch/jump target
//   stall           downstream not consuming the presented instruction
//   imem_req        memory read request
//   imem_addr       memory read address (stable while imem_req=1)
//   imem_ack        memory returns data this cycle
//   imem_rdata      returned instruction word
//   inst_valid      inst/inst_addr hold a fetched instruction
//   inst            fetched instruction word
//   inst_addr       address of inst
//   pc_plus4        inst_addr + 4 (wraps modulo 2^32)
//   fetch_misalign  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic [31:0] pc_plus4,
  output logic        fetch_misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_REQ, S_HOLD} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] imem_addr_q;
  logic        imem_req_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic        discard_q;
  logic [31:0] tgt_d;
  logic [31:0] restart_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        addr_bad_d;
`endif

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt_d      = redirect_addr;
    addr_bad_d = redirect_valid && (redirect_addr[1:0] != 2'b00);
`else
    tgt_d      = redirect_addr & ~32'h3;
`endif
    // Address to fetch after a dropped word: a same-cycle redirect beats the
    // target already captured in pc.
    restart_d  = redirect_valid ? tgt_d : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      imem_addr_q  <= RESET_PC;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_addr_q  <= RESET_PC;
      discard_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (!imem_req_q) begin
            // First cycle out of reset: start the request (acks ignored here).
`ifdef FETCH_MISALIGN_TRAP_EN
            if (addr_bad_d) begin
              misalign_q <= 1'b1;
              state_q    <= S_HALT;
            end else
`endif
            begin
              pc_q        <= restart_d;
              imem_addr_q <= restart_d;
              imem_req_q  <= 1'b1;
            end
          end else if (imem_ack) begin
            if (discard_q || redirect_valid) begin
              discard_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
              if (misalign_q || addr_bad_d) begin
                misalign_q <= 1'b1;
                imem_req_q <= 1'b0;
                state_q    <= S_HALT;
              end else
`endif
              begin
                // Stale word dropped; keep requesting at the new target.
                pc_q        <= restart_d;
                imem_addr_q <= restart_d;
              end
            end else begin
              inst_q       <= imem_rdata;
              inst_addr_q  <= imem_addr_q;
              inst_valid_q <= 1'b1;
              pc_q         <= imem_addr_q + 32'd4;
              imem_req_q   <= 1'b0;
              state_q      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // Request must stay stable until ack; remember the target only.
            pc_q      <= tgt_d;
            discard_q <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (addr_bad_d) misalign_q <= 1'b1;
`endif
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (addr_bad_d) begin
              misalign_q <= 1'b1;
              state_q    <= S_HALT;
            end else
`endif
            begin
              pc_q        <= tgt_d;
              imem_addr_q <= tgt_d;
              imem_req_q  <= 1'b1;
              state_q     <= S_REQ;
            end
          end else if (!stall) begin
            inst_valid_q <= 1'b0;
            imem_addr_q  <= pc_q;
            imem_req_q   <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign pc_plus4   = inst_addr_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = misalign_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        imem_req,  imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst, inst2;
  logic [31:0] inst_addr, inst_addr2;
  logic [31:0] pc_plus4, pc_plus42;
  logic        fetch_misalign, fetch_misalign2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_d;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
    .pc_plus4(pc_plus4), .fetch_misalign(fetch_misalign));

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall(stall), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid2), .inst(inst2), .inst_addr(inst_addr2),
    .pc_plus4(pc_plus42), .fetch_misalign(fetch_misalign2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; redirect_addr = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %h want 0", imem_req); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %h want 0", inst_valid); else n_pass++;
    n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst got %h want 0", inst); else n_pass++;
    n_checks++; if (inst_addr !== 32'h0) $display("FAIL rst_inst_addr got %h want 0", inst_addr); else n_pass++;
    n_checks++; if (pc_plus4 !== 32'h4) $display("FAIL rst_pc_plus4 got %h want 4", pc_plus4); else n_pass++;
    n_checks++; if (fetch_misalign !== 1'b0) $display("FAIL rst_misalign got %h want 0", fetch_misalign); else n_pass++;
    n_checks++; if (inst_addr2 !== 32'hFFFF_FFFC) $display("FAIL rst_inst_addr2 got %h want fffffffc", inst_addr2); else n_pass++;
    step();
    n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req got %h want 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL first_addr got %h want 0", imem_addr); else n_pass++;
  endtask

  // Leaves the DUT presenting the instruction fetched from 0x8.
  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== a) $display("FAIL seq_req got %h/%h want 1/%h", imem_req, imem_addr, a); else n_pass++;
      last_d = $urandom;
      imem_ack = 1'b1; imem_rdata = last_d;
      step();
      imem_ack = 1'b0;
      n_checks++; if (inst_valid !== 1'b1 || inst !== last_d) $display("FAIL seq_inst got %h/%h want 1/%h", inst_valid, inst, last_d); else n_pass++;
      n_checks++; if (inst_addr !== a || pc_plus4 !== a + 32'd4) $display("FAIL seq_addr got %h/%h want %h/%h", inst_addr, pc_plus4, a, a + 32'd4); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL seq_req_drop got %h want 0", imem_req); else n_pass++;
      if (i < 2) begin
        step();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL seq_consume got %h want 0", inst_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = ~last_d;   // acks outside a request are ignored
      step();
      n_checks++; if (inst_valid !== 1'b1 || inst !== last_d || inst_addr !== 32'h8) $display("FAIL stall_hold got %h/%h/%h want 1/%h/8", inst_valid, inst, inst_addr, last_d); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req got %h want 0", imem_req); else n_pass++;
    end
    imem_ack = 1'b0; stall = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || inst_valid !== 1'b0) $display("FAIL stall_release got %h/%h/%h want 1/c/0", imem_req, imem_addr, inst_valid); else n_pass++;
  endtask

  task automatic test_discard();
    imem_ack = 1'b1; imem_rdata = $urandom;
    step();
    imem_ack = 1'b0;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL disc_setup got %h/%h want 1/10", imem_req, imem_addr); else n_pass++;
    redirect_valid = 1'b1; redirect_addr = 32'h200;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL disc_stable got %h/%h want 1/10", imem_req, imem_addr); else n_pass++;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL disc_drop got %h want 0", inst_valid); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL disc_refetch got %h/%h want 1/200", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    imem_ack = 1'b1; imem_rdata = $urandom;
    step();
    imem_ack = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h200) $display("FAIL rs_setup got %h/%h want 1/200", inst_valid, inst_addr); else n_pass++;
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h40;
    step();
    idle_inputs();
    n_checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rs_redirect got %h/%h/%h want 0/1/40", inst_valid, imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) $display("FAIL wrap_req got %h/%h want 1/fffffffc", imem_req2, imem_addr2); else n_pass++;
    imem_ack = 1'b1; imem_rdata = $urandom;
    step();
    imem_ack = 1'b0;
    n_checks++; if (inst_valid2 !== 1'b1 || inst_addr2 !== 32'hFFFF_FFFC || pc_plus42 !== 32'h0) $display("FAIL wrap_inst got %h/%h/%h want 1/fffffffc/0", inst_valid2, inst_addr2, pc_plus42); else n_pass++;
    step();
    n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) $display("FAIL wrap_next got %h/%h want 1/0", imem_req2, imem_addr2); else n_pass++;
  endtask

  task automatic test_misalign();
    do_reset();
    step();
    imem_ack = 1'b1; imem_rdata = $urandom;
    step();
    imem_ack = 1'b0;
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h102;
    step();
    idle_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL mis_trap got %h/%h/%h want 1/0/0", fetch_misalign, imem_req, inst_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      stall = 1'($urandom); imem_ack = 1'($urandom); imem_rdata = $urandom;
      step();
      n_checks++; if (imem_req !== 1'b0 || fetch_misalign !== 1'b1) $display("FAIL mis_halt got %h/%h want 0/1", imem_req, fetch_misalign); else n_pass++;
    end
    idle_inputs();
`else
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_misalign !== 1'b0) $display("FAIL mis_mask got %h/%h/%h want 1/100/0", imem_req, imem_addr, fetch_misalign); else n_pass++;
`endif
  endtask

  // Reference model: tracks what the fetch stage is doing in terms of the
  // fetch protocol (holding an instruction or not, request in flight or not,
  // in-flight word stale or not, where the next fetch goes).
  task automatic test_random();
    bit          holding, requesting, stale;
    logic [31:0] next_pc, req_at, held_word, held_at;
    logic        r, s, a, rs;
    logic [31:0] ra, d;
    do_reset();
    holding = 0; requesting = 0; stale = 0;
    next_pc = 32'h0; req_at = 32'h0; held_word = 32'h0; held_at = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rs = ($urandom_range(0, 59) == 0);
      r  = ($urandom_range(0, 5) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      ra = {$urandom_range(0, 255), 2'b00};
`else
      ra = $urandom_range(0, 1023);
`endif
      s  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 2) != 0);
      d  = $urandom;
      rst = rs; redirect_valid = r; redirect_addr = ra; stall = s; imem_ack = a; imem_rdata = d;
      step();
      ra = ra & ~32'h3;
      if (rs) begin
        holding = 0; requesting = 0; stale = 0;
        next_pc = 32'h0; req_at = 32'h0; held_word = 32'h0; held_at = 32'h0;
      end else if (holding) begin
        if (r || !s) begin
          holding = 0; requesting = 1;
          if (r) next_pc = ra;
          req_at = next_pc;
        end
      end else if (!requesting) begin
        if (r) next_pc = ra;
        req_at = next_pc; requesting = 1;
      end else if (a) begin
        if (stale || r) begin
          if (r) next_pc = ra;
          stale = 0; req_at = next_pc;
        end else begin
          held_word = d; held_at = req_at; holding = 1; requesting = 0;
          next_pc = req_at + 32'd4;
        end
      end else if (r) begin
        next_pc = ra; stale = 1;
      end
      rst = 1'b0;
      n_checks++; if (imem_req !== requesting || (requesting && imem_addr !== req_at)) $display("FAIL rnd_req cyc %0d got %h/%h want %h/%h", cyc, imem_req, imem_addr, requesting, req_at); else n_pass++;
      n_checks++; if (inst_valid !== holding || (holding && inst !== held_word)) $display("FAIL rnd_inst cyc %0d got %h/%h want %h/%h", cyc, inst_valid, inst, holding, held_word); else n_pass++;
      n_checks++; if (inst_addr !== held_at || pc_plus4 !== held_at + 32'd4) $display("FAIL rnd_addr cyc %0d got %h/%h want %h/%h", cyc, inst_addr, pc_plus4, held_at, held_at + 32'd4); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_discard();
    test_redirect_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 redirect_valid  input  1  next-PC logic signals a taken branch/jump this cycle.
REQ-005 redirect_addr  input  32  branch/jump target address.
REQ-006 stall  input  1  downstream not consuming the held instruction.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address, valid while imem_req=1.
REQ-009 imem_ack  input  1  memory returns data this cycle.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 inst_valid  output  1  inst/inst_addr hold a fetched instruction.
REQ-012 inst  output  32  fetched instruction word.
REQ-013 inst_addr  output  32  address of inst (current instruction address to next-PC logic).
REQ-014 pc_plus4  output  32  inst_addr + 4, modulo 2^32.
REQ-015 fetch_misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 FSM states SHALL be REQ (request outstanding), HOLD (instruction presented), HALT (misalign stop).
REQ-017 Internal pc register SHALL hold the next fetch address; imem_addr SHALL come from a separate register latched when a request starts.
REQ-018 In REQ, imem_req=1 and imem_addr SHALL stay stable until the edge at which imem_ack=1.
REQ-019 On ack in REQ without pending discard: inst<=imem_rdata, inst_addr<=imem_addr, inst_valid<=1, pc<=imem_addr+4, state->HOLD, imem_req<=0; latency ack edge to inst_valid = 1 cycle.
REQ-020 pc increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; pc_plus4 likewise.
REQ-021 In HOLD with stall=1 and no redirect: all outputs held.
REQ-022 In HOLD with stall=0 and no redirect: instruction consumed at that edge; inst_valid<=0, imem_req<=1, imem_addr<=pc, state->REQ.
REQ-023 Redirect in HOLD (any stall value): inst_valid<=0, pc<=redirect_addr, imem_addr<=redirect_addr, imem_req<=1, state->REQ; redirect has priority over stall.
REQ-024 Redirect in REQ with imem_ack=0: pc<=redirect_addr, discard flag set; imem_req/imem_addr stay unchanged until ack.
REQ-025 Ack in REQ with discard flag set, or coincident with redirect: data SHALL be dropped (inst, inst_valid unchanged at 0), flag cleared, new request issued next cycle at the redirect address.
REQ-026 Multiple redirects while outstanding: last redirect_addr wins.
REQ-027 imem_ack outside REQ SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge: pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_addr=RESET_PC, discard=0, fetch_misalign=0, state=REQ.
REQ-029 First cycle after rst deasserts SHALL drive imem_req=1, imem_addr=RESET_PC.
REQ-030 Reset mid-request SHALL abandon the request; a late imem_ack before the new request is ignored per REQ-027 (imem_req=0 during reset cycle).

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN SHALL gate misalignment checking.
REQ-032 Defined: redirect with redirect_addr[1:0]!=0 sets fetch_misalign=1, inst_valid<=0, imem_req<=0 (after any outstanding ack), state->HALT; HALT exits only by rst.
REQ-033 Not defined: redirect_addr[1:0] forced to 2'b00 on load, fetch_misalign tied 0, HALT state absent.

Verification
REQ-034 Reset, memory acks 1 cycle after each req, stall=0 -> imem_addr sequence 0x0,0x4,0x8; inst_valid one cycle each; pc_plus4=inst_addr+4.
REQ-035 inst at 0x8 in HOLD, stall=1 for 3 cycles -> inst/inst_addr=0x8 held, imem_req=0 throughout; stall=0 -> next req at 0xC.
REQ-036 Request at 0x10 outstanding, redirect 0x200, ack 2 cycles later with 0xDEADBEEF -> word dropped, inst_valid stays 0, next imem_addr=0x200.
REQ-037 HOLD with stall=1 and redirect 0x40 same cycle -> inst_valid 0 next cycle, imem_req=1, imem_addr=0x40.
REQ-038 RESET_PC=32'hFFFF_FFFC, ack -> inst_addr=0xFFFFFFFC, pc_plus4=0x0, next imem_addr=0x0.
REQ-039 With FETCH_MISALIGN_TRAP_EN, redirect 0x102 -> fetch_misalign=1, imem_req=0 stays 0 until rst; without it -> next imem_addr=0x100.
